mc_control: RTL
===============

# mc_control

Multicycle control sequencer for the mini CPU datapath. Walks each instruction through fetch, decode, execute, memory and write-back states. Drives the enables and mux selects for the PC, instruction register, register file, memory interface, ALU source registers (A/B) and ALU. Stalls on a memory-ready handshake and counts retired fetches for debug.

## Interface
- COUNT_W, 16, width of the fetch counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (datapath ANDs)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ior_d  out  1  0 memory address = PC, 1 = ALUOut
- mem_read / mem_write  out  1 each  memory strobes
- ir_write  out  1  instruction register load
- ab_write  out  1  load enable for A/B ALU source registers
- alu_src_a  out  1  0 PC, 1 A register
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file write controls
- illegal_op  out  1  one-cycle pulse on undecodable opcode
- state  out  4  current state encoding (debug)
- fetch_count  out  COUNT_W  completed fetches, wraps

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 go to FETCH next cycle and drive all outputs 0.
- Outputs are decoded from state, Moore style. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ab_write=1, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX (see Configuration)
  - any other opcode → FETCH, with illegal_op=1 for this DECODE cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, ior_d=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write=1, ior_d=1. Holds until mem_ready, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → ALUWB.
- ALUWB: reg_write=1, reg_dst=1 → FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- opcode is sampled only in DECODE and MEMADR; other states ignore it.

## Timing
- Reset is asynchronous. While reset=0: state=FETCH, fetch_count=0, and every output is forced to 0, including mem_read in FETCH.
- Reset release: the first cycle with reset=1 is FETCH with mem_read=1.
- Reset during a memory wait abandons the access. Strobes drop immediately.
- Latency with mem_ready held at 1:
  - R-type 4 cycles
  - lw 5 cycles
  - sw 4 cycles
  - beq 3 cycles
  - j 3 cycles
  - addi 4 cycles
  - illegal opcode 2 cycles
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. Every output holds its value throughout the wait.
- fetch_count increments on the clock edge that ends a FETCH cycle with mem_ready=1. It wraps from 2^COUNT_W−1 to 0.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

## Configuration
- ADDI_EN defined: opcode 001000 decodes to ADDIEX → ADDIWB.
- ADDI_EN undefined:
  - Opcode 001000 is illegal: illegal_op pulses in DECODE, then FETCH.
  - States 10 and 11 are unreachable and behave like codes 12–15.

## Test plan
- Reset: hold reset=0 with mem_ready=1 → all outputs 0, state=0, fetch_count=0. Release → next cycle mem_read=1, state=0.
- R-type with mem_ready=1 → states 0,1,6,7,0. reg_dst=1 and reg_write=1 in state 7. fetch_count=1.
- lw with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. mem_read and ior_d stay 1 through the wait. reg_write=1 with mem_to_reg=1 in state 4.
- beq then j back-to-back → pc_write_cond=1 with pc_source=01 in state 8, then pc_write=1 with pc_source=10 in state 9. Each takes 3 cycles.
- Opcode 111111, and 001000 built without ADDI_EN → illegal_op is a single pulse in state 1, then state 0. With ADDI_EN, 001000 → states 10, 11, reg_write=1.
- COUNT_W=4: run 16 fetches → fetch_count returns to 0. Asserting reset=0 mid-MEMWR → mem_write drops asynchronously and state=0.

Source files
------------

// File: rtl/mc_control_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : mc_control_if
// Description : Control bundle between the multicycle sequencer and the mini
//               CPU datapath. The sequencer side (master) receives the
//               opcode and memory handshake and drives every enable, mux
//               select and debug output. The datapath side (slave) is the
//               mirror image.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Signals
//   opcode[5:0]      instr[31:26] from the instruction register
//   mem_ready        memory completed the current access this cycle
//   pc_write         unconditional PC load
//   pc_write_cond    PC load qualified by ALU zero
//   pc_source[1:0]   00 ALU result, 01 ALUOut, 10 jump target
//   ior_d            memory address select: 0 PC, 1 ALUOut
//   mem_read         memory read strobe
//   mem_write        memory write strobe
//   ir_write         instruction register load
//   ab_write         A/B ALU source register load
//   alu_src_a        0 PC, 1 A register
//   alu_src_b[1:0]   00 B, 01 const 4, 10 imm, 11 imm<<2
//   alu_op[1:0]      00 add, 01 sub, 10 funct-decoded
//   reg_write        register-file write enable
//   reg_dst          register-file destination select
//   mem_to_reg       register-file write-data select
//   illegal_op       one-cycle pulse on an undecodable opcode
//   state[3:0]       current sequencer state (debug)
//   fetch_count      completed fetches, wrapping (debug)
//----------------------------------------------------------------------------
interface mc_control_if #(
    parameter int COUNT_W = 16
) ();
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               ior_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               ab_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               illegal_op;
    logic [3:0]         state;
    logic [COUNT_W-1:0] fetch_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, ior_d, mem_read, mem_write,
               ir_write, ab_write, alu_src_a, alu_src_b, alu_op, reg_write,
               reg_dst, mem_to_reg, illegal_op, state, fetch_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ior_d, mem_read, mem_write,
               ir_write, ab_write, alu_src_a, alu_src_b, alu_op, reg_write,
               reg_dst, mem_to_reg, illegal_op, state, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : mc_control
// Description : Multicycle control sequencer for the mini CPU datapath.
//               Walks each instruction through fetch, decode, execute,
//               memory and write-back, stalling on mem_ready in the memory
//               states, and counts completed fetches for debug.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset)
//   bus    mc_control_if.master control bundle (see mc_control_if.sv)
// Parameters
//   COUNT_W  width of the fetch counter (must match the interface)
// Build options
//   ADDI_EN  when defined, opcode 001000 executes as addi (ADDIEX/ADDIWB);
//            otherwise it is treated as illegal.
//----------------------------------------------------------------------------
module mc_control #(
    parameter int COUNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    mc_control_if.master  bus
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_ALUWB  = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_ADDIEX = 4'd10;
    localparam logic [3:0] c_ADDIWB = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [COUNT_W-1:0] r_fetch_count;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic [1:0] w_pc_source;
    logic       w_ior_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_ab_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_illegal_op;
    logic       w_fetch_done;

    // Next-state and output decode. Outputs depend on the state only, apart
    // from the FETCH loads (follow mem_ready) and the DECODE illegal pulse.
    always_comb begin
        w_next          = c_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_source     = 2'b00;
        w_ior_d         = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_ab_write      = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_illegal_op    = 1'b0;
        case (r_state)
            c_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
                w_next      = bus.mem_ready ? c_DECODE : c_FETCH;
            end
            c_DECODE: begin
                w_ab_write  = 1'b1;
                w_alu_src_b = 2'b11;
                case (bus.opcode)
                    c_OP_RTYPE:       w_next = c_EXEC;
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_J:           w_next = c_JUMP;
`ifdef ADDI_EN
                    c_OP_ADDI:        w_next = c_ADDIEX;
`endif
                    default: begin
                        w_next       = c_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            c_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                // Only lw/sw reach here; anything but sw is treated as a load.
                w_next      = (bus.opcode == c_OP_SW) ? c_MEMWR : c_MEMRD;
            end
            c_MEMRD: begin
                w_mem_read = 1'b1;
                w_ior_d    = 1'b1;
                w_next     = bus.mem_ready ? c_MEMWB : c_MEMRD;
            end
            c_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            c_MEMWR: begin
                w_mem_write = 1'b1;
                w_ior_d     = 1'b1;
                w_next      = bus.mem_ready ? c_FETCH : c_MEMWR;
            end
            c_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = c_ALUWB;
            end
            c_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            c_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
            end
            c_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
`ifdef ADDI_EN
            c_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = c_ADDIWB;
            end
            c_ADDIWB: begin
                w_reg_write = 1'b1;
            end
`endif
            default: begin
                // Unused codes fall back to FETCH with all outputs low.
                w_next = c_FETCH;
            end
        endcase
    end

    assign w_fetch_done = (r_state == c_FETCH) && bus.mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_FETCH;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_fetch_done) begin
                r_fetch_count <= r_fetch_count + 1'b1;
            end
        end
    end

    // Outputs are gated by reset directly so that strobes drop the moment
    // reset asserts, even in the middle of a memory wait.
    assign bus.pc_write      = reset & w_pc_write;
    assign bus.pc_write_cond = reset & w_pc_write_cond;
    assign bus.pc_source     = reset ? w_pc_source : 2'b00;
    assign bus.ior_d         = reset & w_ior_d;
    assign bus.mem_read      = reset & w_mem_read;
    assign bus.mem_write     = reset & w_mem_write;
    assign bus.ir_write      = reset & w_ir_write;
    assign bus.ab_write      = reset & w_ab_write;
    assign bus.alu_src_a     = reset & w_alu_src_a;
    assign bus.alu_src_b     = reset ? w_alu_src_b : 2'b00;
    assign bus.alu_op        = reset ? w_alu_op : 2'b00;
    assign bus.reg_write     = reset & w_reg_write;
    assign bus.reg_dst       = reset & w_reg_dst;
    assign bus.mem_to_reg    = reset & w_mem_to_reg;
    assign bus.illegal_op    = reset & w_illegal_op;
    assign bus.state         = r_state;
    assign bus.fetch_count   = r_fetch_count;

endmodule
`default_nettype wire
